us_param_bank: RTL and testbench

//  Per-sub-channel ultrasonic acquisition parameter store with shadow/active double buffering.

---
 rtl/us_param_bank.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_us_param_bank.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/us_param_bank.sv
// ---------------------------------------------------------------------------
// us_param_bank
// Per-sub-channel ultrasonic acquisition parameter store.
//  - Host commands update a shadow copy of each sub-channel's parameter set.
//  - A commit copies shadow -> active for one sub-channel or for all of them
//    on the same clock edge, so the sequencer never sees a half-updated set.
//  - A load strobe snapshots active[sub] onto the registered outputs.
//  - A readback command returns one shadow field through a valid/ready
//    holding register; requests arriving while it is busy are dropped.
// ---------------------------------------------------------------------------
module us_param_bank #(
  parameter int          N_SUB       = 8,
  parameter logic [7:0]  DEF_ACCUM   = 8'd10,
  parameter logic [15:0] DEF_VRC_LEN = 16'd150,
  parameter logic [7:0]  DEF_PULSE_W = 8'd24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hw_ch,
  input  logic [31:0] i_cmd_data,
  input  logic        i_cmd_vld,
  input  logic [2:0]  i_sub_channel,
  input  logic        i_load_param,
  output logic        o_param_vld,
  output logic [7:0]  o_accum,
  output logic [15:0] o_delay,
  output logic [2:0]  o_scan_type,
  output logic [10:0] o_scan_len,
  output logic [2:0]  o_sel,
  output logic [10:0] o_start_amp,
  output logic [9:0]  o_amp_porch,
  output logic [19:0] o_ainc_one,
  output logic [19:0] o_ainc_two,
  output logic [15:0] o_vrc_len,
  output logic [2:0]  o_pulse_count,
  output logic [2:0]  o_pulse_mask,
  output logic [7:0]  o_pulse_pause,
  output logic [7:0]  o_pulse_width,
  output logic [31:0] o_rd_data,
  output logic        o_rd_vld,
  input  logic        i_rd_rdy,
  output logic        o_rd_drop
);

  // Sub-channel count as a 4-bit value so 3-bit selectors compare without
  // wrapping when N_SUB is 8.
  localparam logic [3:0] N_SUB_L = 4'(N_SUB);

  // Command opcodes
  localparam logic [3:0] OP_SCAN_LEN  = 4'h1;
  localparam logic [3:0] OP_AINC_ONE  = 4'h2;
  localparam logic [3:0] OP_AINC_TWO  = 4'h3;
  localparam logic [3:0] OP_VRC_LEN   = 4'h4;
  localparam logic [3:0] OP_ACCUM     = 4'h5;
  localparam logic [3:0] OP_DELAY     = 4'h6;
  localparam logic [3:0] OP_SCAN_TYPE = 4'h7;
  localparam logic [3:0] OP_START_AMP = 4'h9;
  localparam logic [3:0] OP_AMP_PORCH = 4'hA;
  localparam logic [3:0] OP_SEL       = 4'hB;
  localparam logic [3:0] OP_PULSE     = 4'hC;
  localparam logic [3:0] OP_COMMIT    = 4'hD;
  localparam logic [3:0] OP_READBACK  = 4'hE;
  localparam logic [3:0] OP_DEFAULTS  = 4'hF;

  // One complete parameter set for a sub-channel
  typedef struct packed {
    logic [7:0]  accum;
    logic [15:0] delay;
    logic [2:0]  scan_type;
    logic [10:0] scan_len;
    logic [2:0]  sel;
    logic [10:0] start_amp;
    logic [9:0]  amp_porch;
    logic [19:0] ainc_one;
    logic [19:0] ainc_two;
    logic [15:0] vrc_len;
    logic [2:0]  pulse_count;
    logic [2:0]  pulse_mask;
    logic [7:0]  pulse_pause;
    logic [7:0]  pulse_width;
  } param_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } rd_state_t;

  // Reset contents of sub-channel idx. sel and pulse_mask default to the
  // sub-channel number; the last sub-channel fires a single pulse.
  function automatic param_t default_set(input int idx);
    param_t p;
    p.accum       = DEF_ACCUM;
    p.delay       = 16'd0;
    p.scan_type   = 3'd1;
    p.scan_len    = 11'd64;
    p.sel         = 3'(idx);
    p.start_amp   = 11'd0;
    p.amp_porch   = 10'd40;
    p.ainc_one    = {10'd20, 10'd0};
    p.ainc_two    = {10'd8, 10'd0};
    p.vrc_len     = DEF_VRC_LEN;
    p.pulse_count = (idx == N_SUB - 1) ? 3'd1 : 3'd4;
    p.pulse_mask  = 3'(idx);
    p.pulse_pause = DEF_PULSE_W;
    p.pulse_width = DEF_PULSE_W;
    return p;
  endfunction

  // Shadow update for one write-type command; non-write opcodes leave the set alone.
  function automatic param_t apply_write(input param_t cur, input logic [3:0] op,
                                         input logic [23:0] pl, input int idx);
    param_t p;
    p = cur;
    case (op)
      OP_SCAN_LEN:  p.scan_len  = pl[10:0];
      OP_AINC_ONE:  p.ainc_one  = pl[19:0];
      OP_AINC_TWO:  p.ainc_two  = pl[19:0];
      OP_VRC_LEN:   p.vrc_len   = pl[15:0];
      OP_ACCUM:     p.accum     = pl[7:0];
      OP_DELAY:     p.delay     = pl[15:0];
      OP_SCAN_TYPE: p.scan_type = pl[2:0];
      OP_START_AMP: p.start_amp = pl[10:0];
      OP_AMP_PORCH: p.amp_porch = pl[9:0];
      OP_SEL:       p.sel       = pl[2:0];
      OP_PULSE:     {p.pulse_count, p.pulse_mask, p.pulse_pause, p.pulse_width} = pl[21:0];
      OP_DEFAULTS:  p = default_set(idx);
      default:      p = cur;
    endcase
    return p;
  endfunction

  // Field selected by a readback selector, zero-extended to 24 bits.
  // Selectors that do not name a field return zero.
  function automatic logic [23:0] rd_value(input param_t p, input logic [3:0] op);
    logic [23:0] v;
    v = '0;
    case (op)
      OP_SCAN_LEN:  v[10:0] = p.scan_len;
      OP_AINC_ONE:  v[19:0] = p.ainc_one;
      OP_AINC_TWO:  v[19:0] = p.ainc_two;
      OP_VRC_LEN:   v[15:0] = p.vrc_len;
      OP_ACCUM:     v[7:0]  = p.accum;
      OP_DELAY:     v[15:0] = p.delay;
      OP_SCAN_TYPE: v[2:0]  = p.scan_type;
      OP_START_AMP: v[10:0] = p.start_amp;
      OP_AMP_PORCH: v[9:0]  = p.amp_porch;
      OP_SEL:       v[2:0]  = p.sel;
      OP_PULSE:     v[21:0] = {p.pulse_count, p.pulse_mask, p.pulse_pause, p.pulse_width};
      default:      v       = '0;
    endcase
    return v;
  endfunction

  // Storage
  param_t shadow_reg [N_SUB];
  param_t active_reg [N_SUB];
  param_t param_out_reg;
  logic   param_vld_reg;

  rd_state_t   rd_state_reg, rd_state_next;
  logic [31:0] rd_data_reg, rd_data_next;
  logic        rd_drop_reg, rd_drop_next;

  // Command fields
  logic        cmd_hw;
  logic [2:0]  cmd_sub;
  logic [3:0]  cmd_op;
  logic [23:0] cmd_payload;
  logic        cmd_acc;
  logic        shadow_wr;
  logic        commit;
  logic        rd_req;

  // Per-sub-channel strobes
  logic [N_SUB-1:0] wr_hit;
  logic [N_SUB-1:0] commit_hit;

  // Muxed sets
  param_t rd_shadow;
  param_t load_set;
  logic   load_ok;

  assign cmd_hw      = i_cmd_data[31];
  assign cmd_sub     = i_cmd_data[30:28];
  assign cmd_op      = i_cmd_data[27:24];
  assign cmd_payload = i_cmd_data[23:0];

  // Decode the command word: addressed to this instance and to an existing sub-channel.
  always_comb begin
    cmd_acc   = i_cmd_vld && (cmd_hw == i_hw_ch) && ({1'b0, cmd_sub} < N_SUB_L);
    commit    = cmd_acc && (cmd_op == OP_COMMIT);
    rd_req    = cmd_acc && (cmd_op == OP_READBACK);
    shadow_wr = cmd_acc && (cmd_op != OP_COMMIT) && (cmd_op != OP_READBACK);
  end

  // Per-sub-channel write and commit strobes; payload[0] of a commit means "all".
  generate
    for (genvar gi = 0; gi < N_SUB; gi++) begin : g_hit
      assign wr_hit[gi]     = shadow_wr && (cmd_sub == 3'(gi));
      assign commit_hit[gi] = commit && (cmd_payload[0] || (cmd_sub == 3'(gi)));
    end
  endgenerate

  // Shadow bank: host writes and restore-defaults land here only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SUB; i++) shadow_reg[i] <= default_set(i);
    end else begin
      for (int i = 0; i < N_SUB; i++) begin
        if (wr_hit[i]) shadow_reg[i] <= apply_write(shadow_reg[i], cmd_op, cmd_payload, i);
      end
    end
  end

  // Active bank: copied from shadow on commit, every hit sub-channel on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SUB; i++) active_reg[i] <= default_set(i);
    end else begin
      for (int i = 0; i < N_SUB; i++) begin
        if (commit_hit[i]) active_reg[i] <= shadow_reg[i];
      end
    end
  end

  // Select the shadow set addressed by the command and the active set to load.
  always_comb begin
    rd_shadow = shadow_reg[0];
    load_set  = active_reg[0];
    for (int i = 0; i < N_SUB; i++) begin
      if (cmd_sub == 3'(i))       rd_shadow = shadow_reg[i];
      if (i_sub_channel == 3'(i)) load_set  = active_reg[i];
    end
    load_ok = i_load_param && ({1'b0, i_sub_channel} < N_SUB_L);
  end

  // Output snapshot: reads the pre-edge active bank, so a same-cycle commit is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      param_out_reg <= default_set(0);
      param_vld_reg <= 1'b0;
    end else begin
      param_vld_reg <= load_ok;
      if (load_ok) param_out_reg <= load_set;
    end
  end

  // Readback state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_reg <= RD_IDLE;
      rd_data_reg  <= '0;
      rd_drop_reg  <= 1'b0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_data_reg  <= rd_data_next;
      rd_drop_reg  <= rd_drop_next;
    end
  end

  // Readback next state: capture in IDLE, freeze and drop new requests in HOLD.
  always_comb begin
    rd_state_next = rd_state_reg;
    rd_data_next  = rd_data_reg;
    rd_drop_next  = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        if (rd_req) begin
          rd_state_next = RD_HOLD;
          rd_data_next  = {cmd_hw, cmd_sub, cmd_payload[3:0],
                           rd_value(rd_shadow, cmd_payload[3:0])};
        end
      end
      RD_HOLD: begin
        if (rd_req)   rd_drop_next  = 1'b1;
        if (i_rd_rdy) rd_state_next = RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  assign o_rd_vld  = (rd_state_reg == RD_HOLD);
  assign o_rd_data = rd_data_reg;
  assign o_rd_drop = rd_drop_reg;

  assign o_param_vld   = param_vld_reg;
  assign o_accum       = param_out_reg.accum;
  assign o_delay       = param_out_reg.delay;
  assign o_scan_type   = param_out_reg.scan_type;
  assign o_scan_len    = param_out_reg.scan_len;
  assign o_sel         = param_out_reg.sel;
  assign o_start_amp   = param_out_reg.start_amp;
  assign o_amp_porch   = param_out_reg.amp_porch;
  assign o_ainc_one    = param_out_reg.ainc_one;
  assign o_ainc_two    = param_out_reg.ainc_two;
  assign o_vrc_len     = param_out_reg.vrc_len;
  assign o_pulse_count = param_out_reg.pulse_count;
  assign o_pulse_mask  = param_out_reg.pulse_mask;
  assign o_pulse_pause = param_out_reg.pulse_pause;
  assign o_pulse_width = param_out_reg.pulse_width;

endmodule

// File: tb/tb_us_param_bank.sv
// ---------------------------------------------------------------------------
// tb_us_param_bank
// Directed scenarios with literal expectations, then randomized traffic.
// The reference model keeps each sub-channel as a table indexed by opcode,
// holding the masked payload last written for that opcode.
// ---------------------------------------------------------------------------
module tb_us_param_bank;

  localparam int N_SUB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_hw_ch;
  logic [31:0] i_cmd_data;
  logic        i_cmd_vld;
  logic [2:0]  i_sub_channel;
  logic        i_load_param;
  logic        i_rd_rdy;
  logic        o_param_vld;
  logic [7:0]  o_accum;
  logic [15:0] o_delay;
  logic [2:0]  o_scan_type;
  logic [10:0] o_scan_len;
  logic [2:0]  o_sel;
  logic [10:0] o_start_amp;
  logic [9:0]  o_amp_porch;
  logic [19:0] o_ainc_one;
  logic [19:0] o_ainc_two;
  logic [15:0] o_vrc_len;
  logic [2:0]  o_pulse_count;
  logic [2:0]  o_pulse_mask;
  logic [7:0]  o_pulse_pause;
  logic [7:0]  o_pulse_width;
  logic [31:0] o_rd_data;
  logic        o_rd_vld;
  logic        o_rd_drop;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  us_param_bank #(.N_SUB(N_SUB)) dut (
    .clk(clk), .rst_n(rst_n), .i_hw_ch(i_hw_ch), .i_cmd_data(i_cmd_data),
    .i_cmd_vld(i_cmd_vld), .i_sub_channel(i_sub_channel), .i_load_param(i_load_param),
    .o_param_vld(o_param_vld), .o_accum(o_accum), .o_delay(o_delay),
    .o_scan_type(o_scan_type), .o_scan_len(o_scan_len), .o_sel(o_sel),
    .o_start_amp(o_start_amp), .o_amp_porch(o_amp_porch), .o_ainc_one(o_ainc_one),
    .o_ainc_two(o_ainc_two), .o_vrc_len(o_vrc_len), .o_pulse_count(o_pulse_count),
    .o_pulse_mask(o_pulse_mask), .o_pulse_pause(o_pulse_pause),
    .o_pulse_width(o_pulse_width), .o_rd_data(o_rd_data), .o_rd_vld(o_rd_vld),
    .i_rd_rdy(i_rd_rdy), .o_rd_drop(o_rd_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bits meaningful for each opcode; zero means "not a field".
  function automatic logic [23:0] op_mask(input int op);
    case (op)
      1, 9:  return 24'h0007FF;
      2, 3:  return 24'h0FFFFF;
      4, 6:  return 24'h00FFFF;
      5:     return 24'h0000FF;
      7, 11: return 24'h000007;
      10:    return 24'h0003FF;
      12:    return 24'h3FFFFF;
      default: return 24'h0;
    endcase
  endfunction

  function automatic logic [23:0] def_val(input int s, input int op);
    int cnt;
    cnt = (s == N_SUB - 1) ? 1 : 4;
    case (op)
      1:  return 24'd64;
      2:  return 24'(20 * 1024);
      3:  return 24'(8 * 1024);
      4:  return 24'd150;
      5:  return 24'd10;
      7:  return 24'd1;
      10: return 24'd40;
      11: return 24'(s);
      12: return 24'(cnt * 524288 + s * 65536 + 24 * 256 + 24);
      default: return 24'd0;
    endcase
  endfunction

  logic [23:0] m_sh [N_SUB][16];
  logic [23:0] m_ac [N_SUB][16];
  logic [23:0] exp_out [16];
  logic        exp_pvld, exp_hold, exp_drop;
  logic [31:0] exp_rd_data;
  logic        m_acc, m_req;
  int          m_sub, m_op, m_ls;
  logic [23:0] m_pl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N_SUB; s++)
        for (int o = 0; o < 16; o++) begin
          m_sh[s][o] = def_val(s, o);
          m_ac[s][o] = def_val(s, o);
        end
      for (int o = 0; o < 16; o++) exp_out[o] = def_val(0, o);
      exp_pvld = 1'b0; exp_hold = 1'b0; exp_drop = 1'b0; exp_rd_data = 32'h0;
    end else begin
      m_sub = int'(i_cmd_data[30:28]);
      m_op  = int'(i_cmd_data[27:24]);
      m_pl  = i_cmd_data[23:0];
      m_ls  = int'(i_sub_channel);
      m_acc = i_cmd_vld && (i_cmd_data[31] == i_hw_ch) && (m_sub < N_SUB);
      // load sees active contents from before this edge's commit
      if (i_load_param && m_ls < N_SUB) begin
        for (int o = 0; o < 16; o++) exp_out[o] = m_ac[m_ls][o];
        exp_pvld = 1'b1;
      end else begin
        exp_pvld = 1'b0;
      end
      m_req    = m_acc && (m_op == 14);
      exp_drop = exp_hold && m_req;
      if (!exp_hold) begin
        if (m_req) begin
          exp_hold    = 1'b1;
          exp_rd_data = {i_cmd_data[31:28], m_pl[3:0], m_sh[m_sub][int'(m_pl[3:0])]};
        end
      end else if (i_rd_rdy) begin
        exp_hold = 1'b0;
      end
      if (m_acc) begin
        if (op_mask(m_op) != 24'h0) m_sh[m_sub][m_op] = m_pl & op_mask(m_op);
        else if (m_op == 15)
          for (int o = 0; o < 16; o++) m_sh[m_sub][o] = def_val(m_sub, o);
        else if (m_op == 13)
          for (int s = 0; s < N_SUB; s++)
            if (m_pl[0] || s == m_sub)
              for (int o = 0; o < 16; o++) m_ac[s][o] = m_sh[s][o];
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("param_vld",   32'(o_param_vld),   32'(exp_pvld));
      check("scan_len",    32'(o_scan_len),    32'(exp_out[1][10:0]));
      check("ainc_one",    32'(o_ainc_one),    32'(exp_out[2][19:0]));
      check("ainc_two",    32'(o_ainc_two),    32'(exp_out[3][19:0]));
      check("vrc_len",     32'(o_vrc_len),     32'(exp_out[4][15:0]));
      check("accum",       32'(o_accum),       32'(exp_out[5][7:0]));
      check("delay",       32'(o_delay),       32'(exp_out[6][15:0]));
      check("scan_type",   32'(o_scan_type),   32'(exp_out[7][2:0]));
      check("start_amp",   32'(o_start_amp),   32'(exp_out[9][10:0]));
      check("amp_porch",   32'(o_amp_porch),   32'(exp_out[10][9:0]));
      check("sel",         32'(o_sel),         32'(exp_out[11][2:0]));
      check("pulse_width", 32'(o_pulse_width), 32'(exp_out[12][7:0]));
      check("pulse_pause", 32'(o_pulse_pause), 32'(exp_out[12][15:8]));
      check("pulse_mask",  32'(o_pulse_mask),  32'(exp_out[12][18:16]));
      check("pulse_count", 32'(o_pulse_count), 32'(exp_out[12][21:19]));
      check("rd_vld",      32'(o_rd_vld),      32'(exp_hold));
      check("rd_drop",     32'(o_rd_drop),     32'(exp_drop));
      check("rd_data",     o_rd_data,          exp_rd_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] d);
    i_cmd_data = d; i_cmd_vld = 1'b1;
    tick();
    i_cmd_vld = 1'b0;
    $display("[TB] cmd 0x%08h  rd_vld=%0b rd_data=0x%08h drop=%0b", d, o_rd_vld, o_rd_data, o_rd_drop);
  endtask

  task automatic load_sub(input logic [2:0] s);
    i_load_param = 1'b1; i_sub_channel = s;
    tick();
    i_load_param = 1'b0;
    $display("[TB] load sub%0d  vld=%0b scan_len=%0d sel=%0d pulse_count=%0d", s, o_param_vld, o_scan_len, o_sel, o_pulse_count);
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  op;
    rst_n = 1'b0; i_hw_ch = 1'b0; i_cmd_data = '0; i_cmd_vld = 1'b0;
    i_sub_channel = '0; i_load_param = 1'b0; i_rd_rdy = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst param_vld", 32'(o_param_vld), 32'd0);
    check("rst rd_vld",    32'(o_rd_vld),    32'd0);
    check("rst rd_data",   o_rd_data,        32'd0);
    check("rst scan_len",  32'(o_scan_len),  32'd64);
    check("rst pulse_cnt", 32'(o_pulse_count), 32'd4);

    // defaults of the last sub-channel
    load_sub(3'd7);
    check("ld7 vld",       32'(o_param_vld),   32'd1);
    check("ld7 pulse_cnt", 32'(o_pulse_count), 32'd1);
    check("ld7 sel",       32'(o_sel),         32'd7);
    check("ld7 scan_len",  32'(o_scan_len),    32'd64);
    tick();
    check("ld7 vld pulse", 32'(o_param_vld),   32'd0);

    // shadow write is invisible until commit
    send_cmd(32'h01000100);
    load_sub(3'd0);
    check("pre-commit scan_len", 32'(o_scan_len), 32'd64);
    send_cmd(32'h0D000000);
    load_sub(3'd0);
    check("post-commit scan_len", 32'(o_scan_len), 32'd256);

    // hw_ch mismatch ignored; readback of sub1 scan_len
    send_cmd(32'h91000100);
    send_cmd(32'h1E000001);
    check("rb vld",  32'(o_rd_vld), 32'd1);
    check("rb data", o_rd_data,     32'h11000040);
    i_rd_rdy = 1'b1; tick(); i_rd_rdy = 1'b0;
    check("rb accepted", 32'(o_rd_vld), 32'd0);

    // held readback with a second request dropped
    send_cmd(32'h0E000005);
    check("hold data 1", o_rd_data, 32'h0500000A);
    tick();
    send_cmd(32'h1E000001);
    check("drop pulse",  32'(o_rd_drop), 32'd1);
    check("hold data 3", o_rd_data,      32'h0500000A);
    tick();
    check("drop cleared", 32'(o_rd_drop), 32'd0);
    check("hold data 4",  o_rd_data,      32'h0500000A);
    check("hold vld 4",   32'(o_rd_vld),  32'd1);
    tick();
    i_rd_rdy = 1'b1; tick(); i_rd_rdy = 1'b0;
    check("hold released", 32'(o_rd_vld), 32'd0);

    // commit-all and load of the same sub in one cycle
    send_cmd(32'h31000123);
    i_cmd_data = 32'h0D000001; i_cmd_vld = 1'b1; i_load_param = 1'b1; i_sub_channel = 3'd3;
    tick();
    i_cmd_vld = 1'b0; i_load_param = 1'b0;
    check("same-cycle old", 32'(o_scan_len), 32'd64);
    load_sub(3'd3);
    check("next load new",  32'(o_scan_len), 32'h123);

    // asynchronous reset while a readback is held
    send_cmd(32'h0E000001);
    check("pre-reset hold", 32'(o_rd_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async rd_vld",  32'(o_rd_vld), 32'd0);
    check("async rd_data", o_rd_data,     32'd0);
    tick(); tick();
    rst_n = 1'b1;
    load_sub(3'd3);
    check("reset sub3 scan_len", 32'(o_scan_len), 32'd64);
    load_sub(3'd0);
    check("reset sub0 scan_len", 32'(o_scan_len), 32'd64);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) i_hw_ch = 1'b1;
      if (c == 3000) begin
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      end
      r  = $urandom();
      op = r[27:24];
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
      i_cmd_data = {($urandom_range(0, 9) == 0) ? ~i_hw_ch : i_hw_ch, r[30:28], op, r[23:0]};
      i_cmd_vld     = ($urandom_range(0, 99) < 60);
      i_load_param  = ($urandom_range(0, 2) == 0);
      i_sub_channel = 3'($urandom_range(0, 7));
      i_rd_rdy      = ($urandom_range(0, 3) == 0);
      tick();
      if (c % 500 == 0)
        $display("[TB] rand cycle %0d cmd=0x%08h vld=%0b load=%0b sub=%0d", c, i_cmd_data, i_cmd_vld, i_load_param, i_sub_channel);
    end
    i_cmd_vld = 1'b0; i_load_param = 1'b0;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
